// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer and the fetch/decode/execute control unit.
// Instruction layout: mode[7], opcode[6:4], regA[3:2], regB[1:0].
package cpu_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int PC_W       = 4;
    localparam int INSTR_W    = 8;
    localparam int CNT_W      = 16;
    localparam int STATE_W    = 3;

    localparam logic [2:0] OPC_ADD     = 3'b001;
    localparam logic [2:0] OPC_INC     = 3'b011;
    localparam logic [3:0] HALT_NIBBLE = 4'b0000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    // A word whose mode+opcode nibble is all zero stops the sequencer.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[7:4] == HALT_NIBBLE;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one registered read port.
// The halt flag looks at the word being read so the sequencer can branch in the fetch cycle.
module instr_mem
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o,
    output logic               rd_halt_o
);

    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o   = rdata_q;
    assign rd_halt_o = is_halt(mem_q[raddr_i]);

endmodule

// File: rtl/program_sequencer.sv
// Issues one instruction at a time to the control unit over valid/ready and waits for writeback.
// Free-run while run is high, or one instruction per step pulse; a halt word parks the FSM.
module program_sequencer
    import cpu_pkg::*;
(
    input  logic               clock_pulse,
    input  logic               reset,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic               step,
    input  logic               restart,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               wb_done,
    output logic [PC_W-1:0]    pc,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    seq_state_t         state_q;
    logic [PC_W-1:0]    pc_q;
    logic               valid_q;
    logic               halted_q;
    logic               step_mode_q;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               mem_we;
    logic               mem_re;
    logic               fetch_halt;
    logic [INSTR_W-1:0] instr_q;

    // Loads are only honoured while nothing is executing.
    assign mem_we = load_en && !reset && (state_q == ST_IDLE || state_q == ST_HALT);
    assign mem_re = (state_q == ST_FETCH);

    always_comb begin
        retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
    end

    instr_mem u_imem (
        .clk_i     (clock_pulse),
        .rst_i     (reset),
        .we_i      (mem_we),
        .waddr_i   (load_addr),
        .wdata_i   (load_data),
        .re_i      (mem_re),
        .raddr_i   (pc_q),
        .rdata_o   (instr_q),
        .rd_halt_o (fetch_halt)
    );

    always_ff @(posedge clock_pulse) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            step_mode_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_en) begin
                        state_q <= ST_IDLE;
                    end else if (restart) begin
                        pc_q <= '0;
                    end else if (run || step) begin
                        state_q     <= ST_FETCH;
                        step_mode_q <= ~run;
                    end
                end
                ST_FETCH: begin
                    if (fetch_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (valid_q && instr_ready) begin
                        state_q <= ST_WAIT;
                        valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wb_done) begin
                        pc_q      <= pc_q + 1'b1;
                        retired_q <= retired_d;
                        state_q   <= (run && !step_mode_q) ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (restart) begin
                        pc_q     <= '0;
                        halted_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: expected issued words go into a queue,
// a monitor checks every accepted instruction, a control-unit model answers with wb_done.
module tb_program_sequencer;
    import cpu_pkg::*;

    localparam logic [7:0] W91 = {1'b1, OPC_ADD, 2'b00, 2'b01}; // 0x91
    localparam logic [7:0] W93 = {1'b1, OPC_ADD, 2'b00, 2'b11}; // 0x93
    localparam logic [7:0] WB5 = {1'b1, OPC_INC, 2'b01, 2'b01}; // 0xB5
    localparam logic [7:0] WHLT = 8'h00;

    logic               clock_pulse = 1'b0;
    logic               reset;
    logic               load_en;
    logic [PC_W-1:0]    load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               run;
    logic               step;
    logic               restart;
    logic               instr_ready;
    logic               wb_auto;
    logic               wb_force;
    logic               wb_done;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic [STATE_W-1:0] state;
    logic               halted;
    logic [CNT_W-1:0]   retired;

    logic [INSTR_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int valid_cycles = 0;
    int cu_lat = 0;
    int vc0;

    assign wb_done = wb_auto | wb_force;

    always #5 clock_pulse = ~clock_pulse;

    program_sequencer dut (
        .clock_pulse (clock_pulse),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .step        (step),
        .restart     (restart),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .wb_done     (wb_done),
        .pc          (pc),
        .state       (state),
        .halted      (halted),
        .retired     (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_pulse);
        #1;
    endtask

    task automatic load_word(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic wait_state(input logic [STATE_W-1:0] st, input int budget, input string name);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(state), 32'(st));
    endtask

    // Monitor: every accepted instruction must match the head of the expected queue.
    initial begin
        logic [INSTR_W-1:0] exp_w;
        forever begin
            @(negedge clock_pulse);
            if (instr_valid === 1'b1) valid_cycles++;
            if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got 0x%0h expected none", instr);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("issued_instr", 32'(instr), 32'(exp_w));
                end
            end
        end
    end

    // Control-unit model: writeback completes cu_lat cycles after acceptance.
    initial begin
        wb_auto = 1'b0;
        forever begin
            @(negedge clock_pulse);
            if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                @(posedge clock_pulse);
                repeat (cu_lat) @(posedge clock_pulse);
                #1 wb_auto = 1'b1;
                @(posedge clock_pulse);
                #1 wb_auto = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; step = 1'b0; restart = 1'b0; instr_ready = 1'b1; wb_force = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_pc", 32'(pc), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_retired", 32'(retired), 0);
        reset = 1'b0;

        // Single step of 0x91.
        load_word(4'd0, W91);
        load_word(4'd1, WHLT);
        cu_lat = 2;
        exp_q.push_back(W91);
        vc0 = valid_cycles;
        pulse_step();
        wait_state(ST_IDLE, 30, "t1_back_idle");
        check("t1_valid_cycles", 32'(valid_cycles - vc0), 1);
        check("t1_pc", 32'(pc), 1);
        check("t1_retired", 32'(retired), 1);

        // Free run into the halt word.
        pulse_restart();
        check("t2_restart_pc", 32'(pc), 0);
        cu_lat = 1;
        exp_q.push_back(W91);
        vc0 = valid_cycles;
        run = 1'b1;
        wait_state(ST_HALT, 50, "t2_halt_state");
        check("t2_halted", 32'(halted), 1);
        check("t2_pc", 32'(pc), 1);
        check("t2_retired", 32'(retired), 2);
        check("t2_instr", 32'(instr), 0);
        check("t2_valid_cycles", 32'(valid_cycles - vc0), 1);
        pulse_step();
        tick();
        check("t2_halt_sticky", 32'(state), 32'(ST_HALT));
        run = 1'b0;
        pulse_restart();
        check("t2_rs_pc", 32'(pc), 0);
        check("t2_rs_halted", 32'(halted), 0);
        check("t2_rs_state", 32'(state), 32'(ST_IDLE));

        // Backpressure with a premature wb_done.
        instr_ready = 1'b0;
        exp_q.push_back(W91);
        pulse_step();
        wait_state(ST_ISSUE, 10, "t3_issue");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_instr", 32'(instr), 32'(W91));
            check("t3_hold_valid", 32'(instr_valid), 1);
            if (i == 2) wb_force = 1'b1;
            tick();
            wb_force = 1'b0;
        end
        instr_ready = 1'b1;
        tick();
        check("t3_wait_state", 32'(state), 32'(ST_WAIT));
        check("t3_valid_drop", 32'(instr_valid), 0);
        check("t3_pc_early", 32'(pc), 0);
        check("t3_retired_early", 32'(retired), 2);
        wait_state(ST_IDLE, 20, "t3_back_idle");
        check("t3_pc", 32'(pc), 1);
        check("t3_retired", 32'(retired), 3);

        // PC wrap over a full memory of 0x93.
        for (int a = 0; a < IMEM_DEPTH; a++) load_word(4'(a), W93);
        pulse_restart();
        cu_lat = 0;
        for (int k = 0; k < 17; k++) exp_q.push_back(W93);
        run = 1'b1;
        begin
            int n = 0;
            while (retired !== 16'd19 && n < 400) begin
                tick();
                n++;
            end
        end
        check("t4_wrap_retired", 32'(retired), 19);
        check("t4_wrap_pc", 32'(pc), 0);
        run = 1'b0;
        wait_state(ST_IDLE, 30, "t4_stop_idle");
        check("t4_final_retired", 32'(retired), 20);
        check("t4_final_pc", 32'(pc), 1);

        // Load beats step; load during WAIT is dropped.
        load_en = 1'b1; load_addr = 4'd2; load_data = WB5; step = 1'b1;
        tick();
        load_en = 1'b0; step = 1'b0;
        check("t5_load_no_fetch", 32'(state), 32'(ST_IDLE));
        check("t5_load_pc", 32'(pc), 1);
        cu_lat = 4;
        exp_q.push_back(W93);
        pulse_step();
        wait_state(ST_IDLE, 30, "t5_step1_idle");
        exp_q.push_back(WB5);
        pulse_step();
        wait_state(ST_WAIT, 20, "t5_in_wait");
        load_word(4'd3, WHLT);
        wait_state(ST_IDLE, 30, "t5_step2_idle");
        exp_q.push_back(W93);
        pulse_step();
        wait_state(ST_IDLE, 30, "t5_step3_idle");
        check("t5_halted", 32'(halted), 0);
        check("t5_pc", 32'(pc), 4);
        check("t5_retired", 32'(retired), 23);

        // Reset while an instruction is on offer.
        instr_ready = 1'b0;
        pulse_step();
        wait_state(ST_ISSUE, 10, "t6_issue");
        check("t6_valid_before", 32'(instr_valid), 1);
        check("t6_instr_before", 32'(instr), 32'(W93));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", 32'(instr_valid), 0);
        check("t6_pc", 32'(pc), 0);
        check("t6_state", 32'(state), 32'(ST_IDLE));
        check("t6_retired", 32'(retired), 0);
        check("t6_instr", 32'(instr), 0);
        instr_ready = 1'b1;
        tick();
        tick();

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
